ro_odometer_ctrl: RTL and testbench

- Sequencer for the ring-oscillator odometer: drives the RO mode pins (ro_sleep, en_ro, en_trans, nmos_g) through stress, settle and measure phases.
- Counts RO output edges during a programmable measurement window and reports the count to the host/register interface.
- Sits between the configuration registers and the ring_oscillator instance; one controller per RO.

---
 rtl/ro_odometer_pkg.sv | 37 +++
 rtl/ro_edge_counter.sv | 68 ++++++
 rtl/ro_odometer_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ro_odometer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_odometer_pkg.sv
// Shared definitions for the ring-oscillator odometer controller.
//   state_e          : sequencer states
//   MODE_*           : 4-bit RO mode vectors {ro_sleep, en_ro, en_trans, nmos_g}
//   MODE_BIT_*       : bit positions of each pin inside a mode vector
//   mode_for_state() : mode vector that goes with a state
package ro_odometer_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StStress,
        StSettle,
        StMeasure,
        StDone
    } state_e;

    localparam int unsigned MODE_BIT_SLEEP    = 3;
    localparam int unsigned MODE_BIT_EN_RO    = 2;
    localparam int unsigned MODE_BIT_EN_TRANS = 1;
    localparam int unsigned MODE_BIT_NMOS_G   = 0;

    localparam logic [3:0] MODE_SLEEP  = 4'b0000;
    localparam logic [3:0] MODE_INIT   = 4'b1010;
    localparam logic [3:0] MODE_MEAS   = 4'b1110;
    localparam logic [3:0] MODE_STRESS = 4'b1001;

    function automatic logic [3:0] mode_for_state(input state_e st);
        logic [3:0] m;
        case (st)
            StStress:  m = MODE_STRESS;
            StSettle:  m = MODE_INIT;
            StMeasure: m = MODE_MEAS;
            default:   m = MODE_SLEEP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// Counts rising edges of an asynchronous RO output in the clk domain.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   ro_i          : RO output, asynchronous to clk_i
//   clr_i         : clear counter and overflow flag (wins over en_i)
//   en_i          : count detected edges this cycle
//   count_nxt_o   : counter value after this clock edge (includes this cycle's edge)
//   ovf_nxt_o     : overflow flag after this clock edge
// The next-state values are exported so the controller can capture the final
// count on the same edge that closes the measurement window.
module ro_edge_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ro_i,
    input  logic             clr_i,
    input  logic             en_i,
    output logic [CNT_W-1:0] count_nxt_o,
    output logic             ovf_nxt_o
);

    logic             sync1_q, sync2_q, prev_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             rise;

    // sync1_q may go metastable; only sync2_q and prev_q feed logic.
    // The synchronizer runs continuously so it has flushed stale history
    // long before a window opens, without inventing a false edge when ro_i
    // is already high at window start.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr_i) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (en_i && rise) begin
            // Saturate; overflow marks that at least one edge was lost.
            if (&count_q) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            sync1_q <= ro_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count_nxt_o = count_d;
    assign ovf_nxt_o   = ovf_d;

endmodule

// File: rtl/ro_odometer_ctrl.sv
// Ring-oscillator odometer sequencer: stress -> settle -> measure -> report.
//   clk, rst          : clock, synchronous active-high reset
//   start, abort      : run one sequence / terminate a running sequence
//   stress_cycles     : stress duration in clk cycles (0 skips stress)
//   meas_cycles       : measurement window in clk cycles (0 behaves as 1)
//   ro_in             : RO output, asynchronous to clk
//   ro_sleep, en_ro, en_trans, nmos_g : registered RO mode pins
//   busy, done        : sequence in progress / 1-cycle completion pulse
//   ro_count, count_valid, overflow   : result of the last completed window
module ro_odometer_ctrl
    import ro_odometer_pkg::*;
#(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned STRESS_W   = 24,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [STRESS_W-1:0] stress_cycles,
    input  logic [WIN_W-1:0]    meas_cycles,
    input  logic                ro_in,
    output logic                ro_sleep,
    output logic                en_ro,
    output logic                en_trans,
    output logic                nmos_g,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    ro_count,
    output logic                count_valid,
    output logic                overflow
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned TMR_W_A  = (STRESS_W > WIN_W) ? STRESS_W : WIN_W;
    localparam int unsigned TMR_W    = (TMR_W_A > SETTLE_W) ? TMR_W_A : SETTLE_W;
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYC - 1);

    state_e           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [WIN_W-1:0] meas_q, meas_d;
    logic [3:0]       mode_q, mode_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] ro_count_q, ro_count_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             cnt_clr, cnt_en;
    logic [CNT_W-1:0] cnt_nxt;
    logic             cnt_ovf_nxt;

    ro_edge_counter #(
        .CNT_W(CNT_W)
    ) u_edge_counter (
        .clk_i      (clk),
        .rst_i      (rst),
        .ro_i       (ro_in),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .count_nxt_o(cnt_nxt),
        .ovf_nxt_o  (cnt_ovf_nxt)
    );

    // Phase timer counts down to zero; the load value is (length - 1) so a
    // phase lasts exactly its programmed number of cycles.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        meas_d     = meas_q;
        ro_count_d = ro_count_q;
        valid_d    = valid_q;
        ovf_d      = ovf_q;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    meas_d  = meas_cycles;
                    valid_d = 1'b0;
                    ovf_d   = 1'b0;
                    if (stress_cycles != '0) begin
                        state_d = StStress;
                        timer_d = TMR_W'(stress_cycles) - TMR_W'(1);
                    end else begin
                        state_d = StSettle;
                        timer_d = SETTLE_LOAD;
                    end
                end
            end
            StStress: begin
                if (timer_q == '0) begin
                    state_d = StSettle;
                    timer_d = SETTLE_LOAD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StSettle: begin
                cnt_clr = 1'b1;
                if (timer_q == '0) begin
                    state_d = StMeasure;
                    timer_d = (meas_q == '0) ? '0 : TMR_W'(meas_q) - TMR_W'(1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StMeasure: begin
                cnt_en = 1'b1;
                if (timer_q == '0) begin
                    // Capture includes an edge detected in the last window cycle.
                    state_d    = StDone;
                    ro_count_d = cnt_nxt;
                    ovf_d      = cnt_ovf_nxt;
                    valid_d    = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Abort discards any result captured this cycle.
        if (abort && (state_q != StIdle)) begin
            state_d    = StIdle;
            timer_d    = '0;
            ro_count_d = ro_count_q;
            ovf_d      = ovf_q;
            valid_d    = 1'b0;
        end

        // Pins and status are registered from the next state so all four
        // mode pins switch on the same edge.
        mode_d = mode_for_state(state_d);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            meas_q     <= '0;
            mode_q     <= MODE_SLEEP;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ro_count_q <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            meas_q     <= meas_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ro_count_q <= ro_count_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
        end
    end

    assign ro_sleep    = mode_q[MODE_BIT_SLEEP];
    assign en_ro       = mode_q[MODE_BIT_EN_RO];
    assign en_trans    = mode_q[MODE_BIT_EN_TRANS];
    assign nmos_g      = mode_q[MODE_BIT_NMOS_G];
    assign busy        = busy_q;
    assign done        = done_q;
    assign ro_count    = ro_count_q;
    assign count_valid = valid_q;
    assign overflow    = ovf_q;

endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// Bench for ro_odometer_ctrl. Time unit is 0.1 ns: clk period 100 (10 ns).
// ro_in toggles at times that are 3 (mod 10), never on a clock edge.
module tb_ro_odometer_ctrl;

    localparam int unsigned CntW   = 8;
    localparam int unsigned WinW   = 16;
    localparam int unsigned StrW   = 24;
    localparam int unsigned Settle = 8;
    localparam int unsigned MaxCnt = (1 << CntW) - 1;

    logic            clk, rst, start, abort, ro_in;
    logic [StrW-1:0] stress_cycles;
    logic [WinW-1:0] meas_cycles;
    logic            ro_sleep, en_ro, en_trans, nmos_g, busy, done, count_valid, overflow;
    logic [CntW-1:0] ro_count;

    ro_odometer_ctrl #(
        .CNT_W     (CntW),
        .WIN_W     (WinW),
        .STRESS_W  (StrW),
        .SETTLE_CYC(Settle)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .stress_cycles(stress_cycles),
        .meas_cycles  (meas_cycles),
        .ro_in        (ro_in),
        .ro_sleep     (ro_sleep),
        .en_ro        (en_ro),
        .en_trans     (en_trans),
        .nmos_g       (nmos_g),
        .busy         (busy),
        .done         (done),
        .ro_count     (ro_count),
        .count_valid  (count_valid),
        .overflow     (overflow)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 0;
    int ro_half = 250;

    initial begin
        clk = 0;
        forever #50 clk = ~clk;
    end

    initial begin
        ro_in = 0;
        #13;
        forever begin
            #(ro_half) ro_in = ~ro_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A sequence accepted at clock edge k0 is described by the offset
    // pos = edge - k0: stress for pos < S, settle for the next Settle edges,
    // measure for the next M, then a single done cycle. An ro_in rise sampled
    // at edge j reaches the counter two edges later and is counted if that
    // edge closes a measure cycle.
    bit          m_act = 0;
    int unsigned m_pos, m_s, m_m, m_edges;
    logic [3:0]  e_mode;
    logic        e_busy, e_done, e_valid, e_ovf;
    int unsigned e_cnt;
    logic        h1 = 0, h2 = 0, h3 = 0;

    task automatic model_step();
        logic        rise;
        int unsigned fin;
        rise   = h2 && !h3;
        e_done = 1'b0;
        if (rst) begin
            m_act   = 0;
            e_mode  = 4'b0000;
            e_busy  = 0;
            e_valid = 0;
            e_cnt   = 0;
            e_ovf   = 0;
        end else if (m_act) begin
            m_pos++;
            fin = m_s + Settle + m_m;
            if (abort) begin
                m_act   = 0;
                e_mode  = 4'b0000;
                e_busy  = 0;
                e_valid = 0;
            end else begin
                if (rise && m_pos >= m_s + Settle + 1 && m_pos <= fin) m_edges++;
                if (m_pos < m_s) e_mode = 4'b1001;
                else if (m_pos < m_s + Settle) e_mode = 4'b1010;
                else if (m_pos < fin) e_mode = 4'b1110;
                else if (m_pos == fin) begin
                    e_mode  = 4'b0000;
                    e_done  = 1;
                    e_valid = 1;
                    e_cnt   = (m_edges > MaxCnt) ? MaxCnt : m_edges;
                    e_ovf   = (m_edges > MaxCnt);
                end else begin
                    m_act  = 0;
                    e_busy = 0;
                end
            end
        end else if (start) begin
            m_act   = 1;
            m_pos   = 0;
            m_s     = stress_cycles;
            m_m     = (meas_cycles == 0) ? 1 : meas_cycles;
            m_edges = 0;
            e_busy  = 1;
            e_valid = 0;
            e_ovf   = 0;
            e_mode  = (m_s != 0) ? 4'b1001 : 4'b1010;
        end
        h3 = h2;
        h2 = h1;
        h1 = ro_in;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("mode", {28'd0, ro_sleep, en_ro, en_trans, nmos_g}, {28'd0, e_mode});
                check("busy", busy, e_busy);
                check("done", done, e_done);
                check("ro_count", ro_count, e_cnt);
                check("count_valid", count_valid, e_valid);
                check("overflow", overflow, e_ovf);
            end
        end
    end

    // ---------------- directed + random stimulus ----------------
    // Starts a sequence and waits for done; reports latency in cycles after
    // the start cycle and how many cycles each mode vector was seen.
    task automatic run_seq(input int s, input int m, input bit inject,
                           output int lat, output int n_st, output int n_in, output int n_me);
        bit got;
        got  = 0;
        lat  = 0;
        n_st = 0;
        n_in = 0;
        n_me = 0;
        @(negedge clk);
        start         = 1;
        stress_cycles = StrW'(s);
        meas_cycles   = WinW'(m);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            start = 0;
            lat++;
            case ({ro_sleep, en_ro, en_trans, nmos_g})
                4'b1001: n_st++;
                4'b1010: n_in++;
                4'b1110: n_me++;
                default: ;
            endcase
            if (inject && en_ro) begin
                start       = 1;
                meas_cycles = WinW'(5);
            end
            if (done) begin
                got = 1;
                break;
            end
        end
        start = 0;
        check("done_seen", got, 1);
    endtask

    initial begin
        int lat, n_st, n_in, n_me, n_done, n_busy;
        rst           = 1;
        start         = 0;
        abort         = 0;
        stress_cycles = '0;
        meas_cycles   = '0;

        @(posedge clk);
        chk_en = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mode", {ro_sleep, en_ro, en_trans, nmos_g}, 4'b0000);
        check("rst_busy", busy, 0);
        check("rst_valid", count_valid, 0);
        check("rst_count", ro_count, 0);
        rst = 0;

        // Nominal run: 50 ns RO period, 20 stress, 100 measure.
        run_seq(20, 100, 0, lat, n_st, n_in, n_me);
        check("run1_latency", lat, 129);
        check("run1_stress_cycles", n_st, 20);
        check("run1_init_cycles", n_in, 8);
        check("run1_meas_cycles", n_me, 100);
        check("run1_count_range", (ro_count >= 19 && ro_count <= 21), 1);
        check("run1_valid", count_valid, 1);

        // Zero stress, zero window.
        run_seq(0, 0, 0, lat, n_st, n_in, n_me);
        check("run2_latency", lat, 10);
        check("run2_stress_cycles", n_st, 0);
        check("run2_meas_cycles", n_me, 1);

        // Saturation: 30 ns period over 900 cycles gives ~300 edges.
        ro_half = 150;
        run_seq(5, 900, 0, lat, n_st, n_in, n_me);
        check("run3_count_sat", ro_count, MaxCnt);
        check("run3_overflow", overflow, 1);
        run_seq(3, 10, 0, lat, n_st, n_in, n_me);
        check("run4_overflow_clear", overflow, 0);
        check("run4_count_range", (ro_count >= 2 && ro_count <= 4), 1);

        // Abort in the fifth stress cycle with a simultaneous start.
        @(negedge clk);
        start         = 1;
        stress_cycles = StrW'(20);
        meas_cycles   = WinW'(50);
        @(negedge clk);
        start = 0;
        repeat (4) @(negedge clk);
        abort       = 1;
        start       = 1;
        meas_cycles = WinW'(7);
        @(negedge clk);
        abort = 0;
        start = 0;
        check("abort_mode", {ro_sleep, en_ro, en_trans, nmos_g}, 4'b0000);
        check("abort_busy", busy, 0);
        check("abort_valid", count_valid, 0);
        n_done = 0;
        n_busy = 0;
        repeat (150) begin
            @(negedge clk);
            n_done += done;
            n_busy += busy;
        end
        check("abort_no_done", n_done, 0);
        check("abort_start_ignored", n_busy, 0);

        // Start pulses during measure must not change the window.
        ro_half = 250;
        run_seq(2, 60, 1, lat, n_st, n_in, n_me);
        check("run6_latency", lat, 71);
        check("run6_meas_cycles", n_me, 60);

        // Reset mid-sequence.
        @(negedge clk);
        start         = 1;
        stress_cycles = StrW'(4);
        meas_cycles   = WinW'(30);
        @(negedge clk);
        start = 0;
        repeat (15) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        check("midrst_busy", busy, 0);
        check("midrst_mode", {ro_sleep, en_ro, en_trans, nmos_g}, 4'b0000);

        // Random traffic against the model.
        for (int it = 0; it < 40; it++) begin
            ro_half = 10 * $urandom_range(11, 40);
            for (int c = 0; c < 150; c++) begin
                @(negedge clk);
                start         = ($urandom % 16 == 0);
                abort         = ($urandom % 80 == 0);
                rst           = ($urandom % 500 == 0);
                stress_cycles = StrW'($urandom_range(0, 30));
                meas_cycles   = WinW'($urandom_range(0, 80));
            end
        end
        @(negedge clk);
        start = 0;
        abort = 0;
        rst   = 0;
        repeat (150) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
